// File: rtl/ws2812_pkg.sv
// Shared opcodes, controller states and colour-byte counts for the WS2812 frame controller.
package ws2812_pkg;

    localparam logic [7:0] CMD_SHOW  = 8'h29;
    localparam logic [7:0] CMD_MASK  = 8'h2A;
    localparam logic [7:0] CMD_ADDR  = 8'h2B;
    localparam logic [7:0] CMD_WRITE = 8'h2C;
    localparam logic [7:0] CMD_MODE  = 8'h2D;

    localparam int BYTES_RGB  = 3;
    localparam int BYTES_RGBW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG_MASK,
        S_ARG_ADDR,
        S_ARG_MODE,
        S_WRITE
    } ctl_state_e;

endpackage

// File: rtl/ws2812_frame_ctl_pixel_ptr.sv
// LED pointer and one-hot colour-byte select; load, clear and mode-dependent wrap.
// Outputs are registered; a load or clear takes effect for the following write.
module pixel_ptr
    import ws2812_pkg::*;
#(
    parameter int LEDS   = 64,
    parameter int ADDR_W = $clog2(LEDS),
    parameter int LOAD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [LOAD_W-1:0] load_val_i,
    input  logic              adv_i,
    input  logic              rgbw_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic [3:0]        sel_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        sel_q, sel_d;
    logic              last_sel;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= '0;
            sel_q <= 4'b0001;
        end else begin
            ptr_q <= ptr_d;
            sel_q <= sel_d;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        last_sel = rgbw_i ? sel_q[BYTES_RGBW-1] : sel_q[BYTES_RGB-1];
        if (clr_i) begin
            ptr_d = '0;
            sel_d = 4'b0001;
        end else if (load_i) begin
            // Out-of-range addresses fall back to LED 0 rather than aliasing.
            if ({{(32-LOAD_W){1'b0}}, load_val_i} >= 32'(LEDS))
                ptr_d = '0;
            else
                ptr_d = load_val_i[ADDR_W-1:0];
            sel_d = 4'b0001;
        end else if (adv_i) begin
            if (last_sel) begin
                sel_d = 4'b0001;
                ptr_d = (ptr_q == ADDR_W'(LEDS-1)) ? '0 : ptr_q + 1'b1;
            end else begin
                sel_d = sel_q << 1;
            end
        end
    end

    assign ptr_o = ptr_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/ws2812_frame_ctl.sv
// Decodes the SPI command/data byte stream into per-channel pixel-buffer writes and a frame-ready pulse.
// All outputs registered, one cycle after byte_rdy_in; accepts one byte per cycle, no backpressure.
module ws2812_frame_ctl
    import ws2812_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int LEDS     = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     dc_in,
    input  logic                     byte_rdy_in,
    input  logic [7:0]               byte_data_in,
    output logic                     frame_rdy_out,
    output logic [CHANNELS-1:0]      wr_en_out,
    output logic [$clog2(LEDS)-1:0]  wr_addr_out,
    output logic [3:0]               byte_sel_out,
    output logic [7:0]               wr_data_out,
    output logic                     rgbw_out
);

    localparam int ADDR_W     = $clog2(LEDS);
    localparam int MASK_BYTES = (CHANNELS + 7) / 8;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int SH_BYTES   = (MASK_BYTES > ADDR_BYTES) ? MASK_BYTES : ADDR_BYTES;
    localparam int SH_W       = SH_BYTES * 8;

    ctl_state_e          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [SH_W-1:0]     shadow_q, shadow_d, shadow_ins;
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                rgbw_q, rgbw_d;
    logic [CHANNELS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          sel_q, sel_d;
    logic [7:0]          data_q, data_d;
    logic                frame_q, frame_d;

    logic                ptr_clr, ptr_load, ptr_adv;
    logic [ADDR_W-1:0]   ptr;
    logic [3:0]          sel;

    pixel_ptr #(
        .LEDS   (LEDS),
        .ADDR_W (ADDR_W),
        .LOAD_W (ADDR_BYTES*8)
    ) u_pixel_ptr (
        .clk_i      (clk_in),
        .rst_n_i    (rst_n_in),
        .clr_i      (ptr_clr),
        .load_i     (ptr_load),
        .load_val_i (shadow_ins[ADDR_BYTES*8-1:0]),
        .adv_i      (ptr_adv),
        .rgbw_i     (rgbw_q),
        .ptr_o      (ptr),
        .sel_o      (sel)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '1;
            rgbw_q   <= 1'b0;
            wr_en_q  <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            data_q   <= '0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            rgbw_q   <= rgbw_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            frame_q  <= frame_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        rgbw_d     = rgbw_q;
        wr_en_d    = '0;
        addr_d     = addr_q;
        sel_d      = sel_q;
        data_d     = data_q;
        frame_d    = 1'b0;
        ptr_clr    = 1'b0;
        ptr_load   = 1'b0;
        ptr_adv    = 1'b0;
        // Argument bytes land in the shadow; live registers change only on the final byte.
        shadow_ins = shadow_q;
        shadow_ins[cnt_q*8 +: 8] = byte_data_in;

        if (byte_rdy_in && !dc_in) begin
            cnt_d    = '0;
            shadow_d = '0;
            case (byte_data_in)
                CMD_MASK:  state_d = S_ARG_MASK;
                CMD_ADDR:  state_d = S_ARG_ADDR;
                CMD_MODE:  state_d = S_ARG_MODE;
                CMD_WRITE: state_d = S_WRITE;
                CMD_SHOW: begin
                    frame_d = 1'b1;
                    ptr_clr = 1'b1;
                    state_d = S_IDLE;
                end
                default:   state_d = S_IDLE;
            endcase
        end else if (byte_rdy_in) begin
            case (state_q)
                S_ARG_MASK: begin
                    if (cnt_q == 3'(MASK_BYTES-1)) begin
                        mask_d  = shadow_ins[CHANNELS-1:0];
                        state_d = S_IDLE;
                    end else begin
                        shadow_d = shadow_ins;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_ARG_ADDR: begin
                    if (cnt_q == 3'(ADDR_BYTES-1)) begin
                        ptr_load = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        shadow_d = shadow_ins;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_ARG_MODE: begin
                    rgbw_d  = byte_data_in[0];
                    ptr_clr = 1'b1;
                    state_d = S_IDLE;
                end
                S_WRITE: begin
                    wr_en_d = mask_q;
                    addr_d  = ptr;
                    sel_d   = sel;
                    data_d  = byte_data_in;
                    ptr_adv = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign frame_rdy_out = frame_q;
    assign wr_en_out     = wr_en_q;
    assign wr_addr_out   = addr_q;
    assign byte_sel_out  = sel_q;
    assign wr_data_out   = data_q;
    assign rgbw_out      = rgbw_q;

endmodule
